slot_mapper_ex: RTL and testbench

SLOT_MAPPER_EX -- requirements
Module: slot_mapper_ex

---
 rtl/slot_mapper_ex.sv | 102 ++++++++++
 tb/tb_slot_mapper_ex.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/slot_mapper_ex.sv
// MSX-style slot decoder with expanded-slot secondary registers and a
// four-segment RAM mapper (I/O ports FCh..FFh) with CPU readback.
module slot_mapper_ex #(
    parameter logic [3:0] EXPANDED = 4'b1000,
    parameter int         SEG_BITS = 3,
    parameter logic [3:0] MAP_SLOT = 4'b1100
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [15:0]            addr,
    input  logic [7:0]             d_in,
    input  logic                   mreq_n,
    input  logic                   iorq_n,
    input  logic                   rd_n,
    input  logic                   wr_n,
    input  logic                   m1_n,
    input  logic                   rfrsh_n,
    input  logic [7:0]             prim_sel,
    output logic [3:0]             sltsl_n,
    output logic [1:0]             sub_sel,
    output logic                   map_cs_n,
    output logic [SEG_BITS+13:0]   map_addr,
    output logic [7:0]             d_out,
    output logic                   d_oe
);

    logic [7:0]          ssr_q [4];
    logic [7:0]          ssr_d [4];
    logic [SEG_BITS-1:0] seg_q [4];
    logic [SEG_BITS-1:0] seg_d [4];
    logic                wr_prev_q;
    logic                wr_prev_d;

    logic [1:0] page;
    logic [1:0] slot;
    logic       slot_exp;
    logic       mem_act;
    logic       io_act;
    logic       ssr_acc;
    logic       seg_hit;
    logic       commit;

    always_comb begin
        page     = addr[15:14];
        slot     = prim_sel[{page, 1'b0} +: 2];
        slot_exp = EXPANDED[slot];
        sub_sel  = slot_exp ? ssr_q[slot][{page, 1'b0} +: 2] : 2'b00;
        mem_act  = !mreq_n && rfrsh_n;
        // m1_n low on an I/O cycle is interrupt acknowledge, not a port access
        io_act   = !iorq_n && m1_n;
        // FFFFh in an expanded slot reaches the SSR, never the slot itself
        ssr_acc  = mem_act && slot_exp && (addr == 16'hFFFF) && (!rd_n || !wr_n);
        seg_hit  = io_act && (addr[7:2] == 6'h3F);

        // Edge-detect the write strobe so a held strobe commits once
        wr_prev_d = !wr_n && (mem_act || io_act);
        commit    = wr_prev_d && !wr_prev_q;

        ssr_d = ssr_q;
        if (commit && ssr_acc) begin
            ssr_d[slot] = d_in;
        end
        seg_d = seg_q;
        if (commit && seg_hit) begin
            seg_d[addr[1:0]] = d_in[SEG_BITS-1:0];
        end

        sltsl_n = 4'hF;
        if (mem_act && !ssr_acc) begin
            sltsl_n[slot] = 1'b0;
        end
        map_cs_n = !(mem_act && !ssr_acc && ({slot, sub_sel} == MAP_SLOT));
        map_addr = {seg_q[page], addr[13:0]};

        d_out = 8'hFF;
        d_oe  = 1'b0;
        if (ssr_acc && !rd_n) begin
            d_out = ~ssr_q[slot];
            d_oe  = 1'b1;
        end else if (seg_hit && !rd_n) begin
            d_out[SEG_BITS-1:0] = seg_q[addr[1:0]];
            d_oe  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_prev_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                ssr_q[i] <= 8'h00;
                seg_q[i] <= SEG_BITS'(3 - i);
            end
        end else begin
            wr_prev_q <= wr_prev_d;
            for (int i = 0; i < 4; i++) begin
                ssr_q[i] <= EXPANDED[i] ? ssr_d[i] : 8'h00;
                seg_q[i] <= seg_d[i];
            end
        end
    end

endmodule

// File: tb/tb_slot_mapper_ex.sv
// Directed bench for slot_mapper_ex at default parameters (slot 3 expanded,
// 3-bit segments, mapper in slot 3-0).
module tb_slot_mapper_ex;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] addr;
    logic [7:0]  d_in;
    logic        mreq_n, iorq_n, rd_n, wr_n, m1_n, rfrsh_n;
    logic [7:0]  prim_sel;
    logic [3:0]  sltsl_n;
    logic [1:0]  sub_sel;
    logic        map_cs_n;
    logic [16:0] map_addr;
    logic [7:0]  d_out;
    logic        d_oe;

    int n_vec = 0;
    int n_err = 0;

    slot_mapper_ex dut (
        .clk(clk), .reset(reset), .addr(addr), .d_in(d_in),
        .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
        .m1_n(m1_n), .rfrsh_n(rfrsh_n), .prim_sel(prim_sel),
        .sltsl_n(sltsl_n), .sub_sel(sub_sel), .map_cs_n(map_cs_n),
        .map_addr(map_addr), .d_out(d_out), .d_oe(d_oe)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bus_idle();
        mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
        m1_n = 1'b1; rfrsh_n = 1'b1;
    endtask

    // Finish the current cycle and give the strobe history one idle clock.
    task automatic end_cycle();
        @(negedge clk);
        bus_idle();
        @(posedge clk);
    endtask

    task automatic mem_wr(input logic [15:0] a, input logic [7:0] d, input logic [3:0] exp_sl);
        @(negedge clk);
        addr = a; d_in = d; mreq_n = 1'b0; wr_n = 1'b0;
        #1 check("wr_sltsl", sltsl_n, exp_sl);
        @(posedge clk);
        end_cycle();
    endtask

    task automatic mem_rd(input logic [15:0] a);
        @(negedge clk);
        addr = a; mreq_n = 1'b0; rd_n = 1'b0;
        #1;
    endtask

    // Data changes after the first edge to expose any repeated commit.
    task automatic io_wr(input logic [7:0] port, input logic [7:0] d, input int hold,
                         input logic [7:0] late_d, input logic m1);
        @(negedge clk);
        addr = {8'h00, port}; d_in = d; iorq_n = 1'b0; wr_n = 1'b0; m1_n = m1;
        @(posedge clk);
        @(negedge clk);
        d_in = late_d;
        repeat (hold - 1) @(posedge clk);
        end_cycle();
    endtask

    task automatic io_rd_chk(input string tag, input logic [7:0] port, input logic m1,
                             input logic [7:0] exp_d, input logic exp_oe);
        @(negedge clk);
        addr = {8'h00, port}; iorq_n = 1'b0; rd_n = 1'b0; m1_n = m1;
        #1;
        check({tag, "_d"}, d_out, exp_d);
        check({tag, "_oe"}, d_oe, exp_oe);
        end_cycle();
    endtask

    initial begin
        bus_idle();
        reset = 1'b1; addr = 16'h0000; d_in = 8'h00; prim_sel = 8'hC0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("idle_sltsl", sltsl_n, 4'hF);
        check("idle_mapcs", map_cs_n, 1'b1);
        check("idle_dout", d_out, 8'hFF);
        check("idle_doe", d_oe, 1'b0);

        // Reset values of the segment registers and SSR
        io_rd_chk("rst_seg0", 8'hFC, 1'b1, 8'hFB, 1'b1);
        io_rd_chk("rst_seg1", 8'hFD, 1'b1, 8'hFA, 1'b1);
        io_rd_chk("rst_seg2", 8'hFE, 1'b1, 8'hF9, 1'b1);
        io_rd_chk("rst_seg3", 8'hFF, 1'b1, 8'hF8, 1'b1);
        mem_rd(16'hFFFF);
        check("rst_ssr", d_out, 8'hFF);
        check("rst_ssr_oe", d_oe, 1'b1);
        end_cycle();

        // Secondary slot register write and readback
        mem_wr(16'hFFFF, 8'hE4, 4'hF);
        mem_rd(16'hFFFF);
        check("ssr_rd", d_out, 8'h1B);
        check("ssr_rd_oe", d_oe, 1'b1);
        check("ssr_rd_sltsl", sltsl_n, 4'hF);
        end_cycle();
        mem_rd(16'hC000);
        check("c000_sub", sub_sel, 2'd3);
        check("c000_sltsl", sltsl_n, 4'h7);
        check("c000_mapcs", map_cs_n, 1'b1);
        check("c000_doe", d_oe, 1'b0);
        end_cycle();
        mem_rd(16'h0000);
        check("0000_sub", sub_sel, 2'd0);
        check("0000_sltsl", sltsl_n, 4'hE);
        end_cycle();

        // Segment write with discarded upper bits, then mapper hit
        io_wr(8'hFD, 8'h0D, 1, 8'h0D, 1'b1);
        io_rd_chk("seg1", 8'hFD, 1'b1, 8'hFD, 1'b1);
        prim_sel = 8'hCC;
        mem_wr(16'hFFFF, 8'hE0, 4'hF);
        mem_rd(16'h4123);
        check("map_addr", map_addr, 17'h14123);
        check("map_cs", map_cs_n, 1'b0);
        check("map_sltsl", sltsl_n, 4'h7);
        check("map_sub", sub_sel, 2'd0);
        end_cycle();

        // Held strobes commit once each
        io_wr(8'hFE, 8'h02, 5, 8'h07, 1'b1);
        io_rd_chk("hold1", 8'hFE, 1'b1, 8'hFA, 1'b1);
        io_wr(8'hFE, 8'h05, 5, 8'h01, 1'b1);
        io_rd_chk("hold2", 8'hFE, 1'b1, 8'hFD, 1'b1);

        // Interrupt acknowledge I/O cycles are ignored
        io_wr(8'hFF, 8'h07, 1, 8'h07, 1'b0);
        io_rd_chk("inta_rd", 8'hFF, 1'b0, 8'hFF, 1'b0);
        io_rd_chk("inta_wr", 8'hFF, 1'b1, 8'hF8, 1'b1);

        // Refresh cycles select nothing
        @(negedge clk);
        addr = 16'h4123; mreq_n = 1'b0; rfrsh_n = 1'b0;
        #1;
        check("rfsh_sltsl", sltsl_n, 4'hF);
        check("rfsh_mapcs", map_cs_n, 1'b1);
        end_cycle();

        // FFFFh in a non-expanded slot: normal select, SSR untouched
        prim_sel = 8'h00;
        mem_wr(16'hFFFF, 8'hAA, 4'hE);
        prim_sel = 8'hCC;
        mem_rd(16'hFFFF);
        check("nonexp_ssr", d_out, 8'h1F);
        end_cycle();

        // Reset dominates a coincident SSR write
        @(negedge clk);
        reset = 1'b1; addr = 16'hFFFF; d_in = 8'h55; mreq_n = 1'b0; wr_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus_idle();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        mem_rd(16'hFFFF);
        check("rstwr_ssr", d_out, 8'hFF);
        end_cycle();
        io_rd_chk("rstwr_seg1", 8'hFD, 1'b1, 8'hFA, 1'b1);
        io_rd_chk("rstwr_seg2", 8'hFE, 1'b1, 8'hF9, 1'b1);

        // Strobe already low at reset release commits once afterwards
        @(negedge clk);
        reset = 1'b1; addr = 16'h00FC; d_in = 8'h0E; iorq_n = 1'b0; wr_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        d_in = 8'h01;
        @(posedge clk);
        end_cycle();
        io_rd_chk("rel_seg0", 8'hFC, 1'b1, 8'hFE, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
